// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / memory-stall controller.
//
// Resolves load-use hazards (one bubble), taken branches (flush IF/ID and
// ID/EX) and data-memory stalls (freeze the whole front of the pipeline and
// bubble MEM/WB) for a classic 5-stage pipeline.
//
// Ports:
//   clk, clr           clock (rising edge) and asynchronous active-high reset
//   id_rs, id_rt       source registers of the instruction in ID
//   ex_writeReg        destination register of the instruction in EX
//   ex_RegWrite        EX instruction writes a register
//   ex_MemToReg        EX instruction is a load
//   branch_taken       branch/jump resolved taken in EX
//   mem_req, mem_ack   MEM-stage access pending / completing this cycle
//   pc_en .. exmem_en  load enables for PC and the pipeline registers
//   ifid_clr .. memwb_clr  synchronous bubble insertion
//   state              RUN=0, MEM_WAIT=1, ERR=2
//   wait_cycles        cycles in the current/last MEM_WAIT, saturates at 255
//   lu_stalls          load-use stall count, wraps
//   mem_timeout        set while in ERR
//
// Build option: define PIPE_CTRL_TIMEOUT_EN to enable the memory timeout
// (MEM_WAIT -> ERR after TIMEOUT cycles). Without it ERR is unreachable.

module pipe_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [5:0]  id_rs,
   input  logic [5:0]  id_rt,
   input  logic [5:0]  ex_writeReg,
   input  logic        ex_RegWrite,
   input  logic        ex_MemToReg,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ack,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_clr,
   output logic        idex_clr,
   output logic        memwb_clr,
   output logic [1:0]  state,
   output logic [7:0]  wait_cycles,
   output logic [15:0] lu_stalls,
   output logic        mem_timeout
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StErr     = 2'd2
   } state_e;

   localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [7:0]  r_wait;
   logic [15:0] r_lu_stalls;
   logic        w_lu;
   logic        w_freeze;
   logic        w_stall;

   // Register 0 is hard-wired zero, so a load targeting it never hazards.
   assign w_lu = ex_MemToReg & ex_RegWrite & (ex_writeReg != 6'd0) &
                 ((ex_writeReg == id_rs) | (ex_writeReg == id_rt));

   assign w_freeze = (r_state == StErr) | (mem_req & ~mem_ack);

   // Load-use bubble only when neither a freeze nor a branch takes priority.
   assign w_stall = ~w_freeze & ~branch_taken & w_lu;

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= StRun;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StRun: begin
            if (mem_req & ~mem_ack) begin
               w_state_nxt = StMemWait;
            end
         end
         StMemWait: begin
            if (mem_ack) begin
               w_state_nxt = StRun;
`ifdef PIPE_CTRL_TIMEOUT_EN
            end else if (r_wait == LastWait) begin
               w_state_nxt = StErr;
`endif
            end
         end
         StErr:   w_state_nxt = StErr;  // only clr leaves ERR
         default: w_state_nxt = StRun;
      endcase
   end

   // Output logic: freeze > branch > load-use > normal flow
   always_comb begin
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      idex_en   = 1'b1;
      exmem_en  = 1'b1;
      ifid_clr  = 1'b0;
      idex_clr  = 1'b0;
      memwb_clr = 1'b0;
      if (w_freeze) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         idex_en   = 1'b0;
         exmem_en  = 1'b0;
         memwb_clr = 1'b1;
      end else if (branch_taken) begin
         ifid_clr = 1'b1;
         idex_clr = 1'b1;
      end else if (w_lu) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_clr = 1'b1;
      end
   end

   // Counters
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_wait      <= 8'd0;
         r_lu_stalls <= 16'd0;
      end else begin
         if (r_state == StRun && w_state_nxt == StMemWait) begin
            r_wait <= 8'd0;
         end else if (r_state == StMemWait && !mem_ack && r_wait != 8'hFF) begin
            r_wait <= r_wait + 8'd1;
         end
         if (w_stall) begin
            r_lu_stalls <= r_lu_stalls + 16'd1;
         end
      end
   end

   assign state       = r_state;
   assign wait_cycles = r_wait;
   assign lu_stalls   = r_lu_stalls;

`ifdef PIPE_CTRL_TIMEOUT_EN
   // ERR is sticky until clr, so the flag is sticky too.
   assign mem_timeout = (r_state == StErr);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^LastWait;
   assign mem_timeout      = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, number of MEM_WAIT cycles tolerated before an error (range 2..255).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-high.
REQ-004 id_rs  in  6  source register A of instruction in ID.
REQ-005 id_rt  in  6  source register B of instruction in ID.
REQ-006 ex_writeReg  in  6  destination register of instruction in EX.
REQ-007 ex_RegWrite  in  1  EX instruction writes a register.
REQ-008 ex_MemToReg  in  1  EX instruction is a load.
REQ-009 branch_taken  in  1  branch/jump resolved taken in EX.
REQ-010 mem_req  in  1  MEM stage holds a valid data-memory access.
REQ-011 mem_ack  in  1  data memory completes the access this cycle.
REQ-012 pc_en, ifid_en, idex_en, exmem_en  out  1 each  load enables for PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-013 ifid_clr, idex_clr, memwb_clr  out  1 each  synchronous bubble insertion for IF/ID, ID/EX and MEM/WB.
REQ-014 state  out  2  FSM state: RUN=0, MEM_WAIT=1, ERR=2.
REQ-015 wait_cycles  out  8  cycles spent in the current/last MEM_WAIT, saturating at 255.
REQ-016 lu_stalls  out  16  load-use stall count, wraps modulo 65536.
REQ-017 mem_timeout  out  1  sticky memory-timeout flag.

Function
REQ-018 lu = ex_MemToReg & ex_RegWrite & (ex_writeReg != 0) & (ex_writeReg == id_rs | ex_writeReg == id_rt); register 0 never hazards.
REQ-019 freeze = (state == ERR) | (mem_req & !mem_ack), valid in RUN and MEM_WAIT.
REQ-020 freeze: pc_en=ifid_en=idex_en=exmem_en=0, ifid_clr=idex_clr=0, memwb_clr=1; overrides branch and lu.
REQ-021 no freeze, branch_taken: all enables 1, ifid_clr=idex_clr=1, memwb_clr=0; branch wins over lu, no stall.
REQ-022 no freeze, no branch, lu: pc_en=ifid_en=0, idex_en=exmem_en=1, idex_clr=1, memwb_clr=0; exactly one bubble per load-use.
REQ-023 Otherwise: all enables 1, all clr 0.
REQ-024 Enables/clears are combinational from state and inputs; state and counters are registered.
REQ-025 RUN -> MEM_WAIT when mem_req & !mem_ack; RUN stays RUN otherwise.
REQ-026 MEM_WAIT -> RUN on mem_ack (pipeline advances that same cycle); stays while !mem_ack.
REQ-027 wait_cycles cleared to 0 on the RUN->MEM_WAIT transition, increments each MEM_WAIT cycle without mem_ack, saturates at 255, holds in RUN.
REQ-028 lu_stalls increments by 1 on each cycle where REQ-022 applies.
REQ-029 mem_ack without mem_req is ignored.

Reset
REQ-030 clr: state=RUN, wait_cycles=0, lu_stalls=0, mem_timeout=0, effective immediately and asynchronously, including mid-MEM_WAIT or in ERR.
REQ-031 After clr release, outputs follow REQ-020..023 from RUN on the next edge.

Configuration
REQ-032 Macro PIPE_CTRL_TIMEOUT_EN defined: in MEM_WAIT, !mem_ack with wait_cycles == TIMEOUT-1 -> ERR; ERR holds until clr; mem_timeout=1 while in ERR.
REQ-033 Macro undefined: ERR unreachable, mem_timeout tied 0, MEM_WAIT waits indefinitely; TIMEOUT ignored.

Verification
REQ-034 ex load to r5, id_rs=5, no mem_req -> one cycle pc_en=0, ifid_en=0, idex_clr=1; lu_stalls 0->1.
REQ-035 load to r0 with id_rs=0 -> no stall, lu_stalls unchanged; branch_taken with lu -> ifid_clr=idex_clr=1, pc_en=1, no count.
REQ-036 mem_req=1, mem_ack low 3 cycles then high -> state 0,1,1,1->0; enables 0 for 3 cycles, 1 on ack cycle; wait_cycles=2 afterwards; memwb_clr=1 during freeze.
REQ-037 TIMEOUT=4, PIPE_CTRL_TIMEOUT_EN, mem_ack never -> ERR after 5 frozen cycles, mem_timeout=1, enables 0 until clr; clr -> state 0, flag 0.
REQ-038 Same stimulus without macro -> state stays 1, wait_cycles saturates at 255 after 256 cycles, mem_timeout=0.
REQ-039 clr pulsed mid-MEM_WAIT, between edges -> state=0, counters=0 immediately.
